bht_access_scheduler: RTL
=========================

Name: bht_access_scheduler

Overview:
- Sequences the single-ported 16-entry BHT of the global predictor. The BHT has one index port, shared by read and write.
- Arbitrates per cycle between fetch-side prediction lookups and execute-side resolved-branch updates.
- Buffers updates in a small FIFO and owns the global history register (GHR).
- Forms the BHT index as pc XOR GHR, and drives the BHT's index, update-enable and outcome inputs.

Parameters:
- DEPTH, 4, update FIFO entries (power of 2, 2..16).
- STARVE_LIMIT, 8, cycles a non-empty FIFO may wait without an update grant before one is forced (1..255).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- lookup_valid  in  1  fetch requests a prediction.
- lookup_pc  in  4  low PC bits of the branch.
- lookup_ready  out  1  lookup granted this cycle (combinational).
- pred_valid  out  1  prediction result valid (registered).
- pred_taken  out  1  predicted direction.
- pred_index  out  4  BHT index used; fetch carries it to resolve.
- upd_valid  in  1  resolved branch presented.
- upd_index  in  4  index returned from pred_index.
- upd_outcome  in  1  actual direction (1 = taken).
- upd_ready  out  1  FIFO can accept (count < DEPTH).
- bht_index  out  4  to BHT index.
- bht_update_en  out  1  to BHT predict_enable (write strobe).
- bht_outcome  out  1  to BHT actual_outcome.
- bht_prediction  in  1  from BHT prediction.

Behaviour:
- Reset (async, reset_n=0):
  - FIFO empty; GHR=0; state=NORMAL; wait_cnt=0.
  - pred_valid=0, pred_taken=0, pred_index=0.
  - Outputs: bht_update_en=0, bht_index=0, bht_outcome=0, lookup_ready=0.
  - Reset mid-operation discards all queued updates.
- Grant rule: exactly one of LOOKUP, UPDATE or IDLE per cycle; never both.
- Enqueue:
  - Occurs on upd_valid & upd_ready; writes {upd_index, upd_outcome} at the tail.
  - An entry enqueued in cycle N is first eligible for grant in cycle N+1.
  - Enqueue and dequeue in the same cycle are allowed when count < DEPTH; count is unchanged.
  - upd_ready depends only on the registered count.
- State NORMAL:
  - wait_cnt == STARVE_LIMIT and FIFO non-empty → UPDATE (lookup_ready=0).
  - Else lookup_valid → LOOKUP.
  - Else FIFO non-empty → UPDATE.
  - Else IDLE.
- State DRAIN:
  - FIFO non-empty → UPDATE every cycle; lookup_ready=0.
- Transitions:
  - NORMAL→DRAIN when the registered count == DEPTH at the clock edge (checked after that cycle's enq/deq).
  - DRAIN→NORMAL when the post-edge count <= DEPTH/2.
- wait_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle the FIFO is non-empty and no UPDATE is granted.
  - Clears on any UPDATE grant or when the FIFO is empty.
- LOOKUP:
  - bht_index = lookup_pc ^ GHR; bht_update_en=0.
  - Next edge: pred_valid=1, pred_taken=bht_prediction, pred_index=bht_index. Latency is 1 cycle.
  - pred_valid=0 in any cycle following a non-LOOKUP cycle.
- UPDATE:
  - bht_index=head.index; bht_outcome=head.outcome; bht_update_en=1.
  - Pop the head; GHR <= {GHR[2:0], head.outcome}.
- IDLE: bht_index=0, bht_update_en=0, bht_outcome=0.
- GHR is non-speculative and changes only on UPDATE. A lookup uses the GHR value before the edge.
- Index arithmetic is 4-bit XOR, with no carry.
- FIFO pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro: BHT_SCHED_PERF_EN.
- Defined:
  - Extra outputs lookup_stall_cnt[15:0] counts cycles with lookup_valid & !lookup_ready.
  - Extra outputs forced_upd_cnt[15:0] counts UPDATE grants caused by starvation or DRAIN.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Reset, GHR=0, lookup_pc=4'h5 with all counters 00 → next cycle pred_valid=1, pred_taken=0, pred_index=4'h5.
- Enqueue {idx 5, taken} 3 times with no lookups → bht_update_en pulses 3 cycles at bht_index=5. GHR=4'b0111. Lookup pc=4'h2 → pred_index=4'h5, pred_taken=1 (counter 11).
- lookup_valid held high, one update queued, STARVE_LIMIT=8 → lookups granted 8 cycles. Cycle 9: lookup_ready=0 and update granted.
- Fill FIFO to 4 while lookup_valid=1 → upd_ready=0, enters DRAIN. Two updates are granted back to back and lookup_ready=0. Returns to NORMAL at count 2, and lookup_ready=1 the following cycle.
- Assert reset_n=0 mid-DRAIN with 3 entries queued → FIFO empty, GHR=0, bht_update_en=0 immediately (async). No further updates after release.
- Simultaneous upd_valid into an empty FIFO and lookup_valid=0 → IDLE this cycle; UPDATE granted the next cycle.

Source files
------------

// File: rtl/bht_access_scheduler.sv
// -----------------------------------------------------------------------------
// bht_access_scheduler
//
// Controls access to the single-ported 16-entry branch history table (BHT) of
// the global predictor. Each cycle the scheduler grants exactly one of three
// things to the shared index port: a fetch-side prediction LOOKUP, an
// execute-side UPDATE, or IDLE.
//
// Resolved-branch updates are held in a small FIFO until they are granted. The
// scheduler owns the non-speculative global history register (GHR), and it
// forms the lookup index as lookup_pc XOR GHR.
//
// Parameters
//   DEPTH         update FIFO entries (power of 2, 2..16)
//   STARVE_LIMIT  cycles a non-empty FIFO may wait for an update grant before
//                 a grant is forced (1..255)
//
// Ports
//   clk, reset_n            clock and asynchronous active-low reset
//   lookup_valid/pc/ready   prediction request; ready is the combinational grant
//   pred_valid/taken/index  registered prediction result, one cycle after grant
//   upd_valid/index/outcome resolved-branch update into the FIFO
//   upd_ready               FIFO can accept (registered count < DEPTH)
//   bht_index/update_en/outcome  drive the BHT index port and write strobe
//   bht_prediction          BHT read data for the current index
//
// Optional build macro BHT_SCHED_PERF_EN adds two saturating 16-bit counters:
//   lookup_stall_cnt  cycles with lookup_valid high and no lookup grant
//   forced_upd_cnt    update grants caused by starvation or by DRAIN
// -----------------------------------------------------------------------------
module bht_access_scheduler #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        lookup_valid,
   input  logic [3:0]  lookup_pc,
   output logic        lookup_ready,
   output logic        pred_valid,
   output logic        pred_taken,
   output logic [3:0]  pred_index,
   input  logic        upd_valid,
   input  logic [3:0]  upd_index,
   input  logic        upd_outcome,
   output logic        upd_ready,
   output logic [3:0]  bht_index,
   output logic        bht_update_en,
   output logic        bht_outcome,
   input  logic        bht_prediction
`ifdef BHT_SCHED_PERF_EN
   ,
   output logic [15:0] lookup_stall_cnt,
   output logic [15:0] forced_upd_cnt
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_C   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(DEPTH / 2);
   localparam logic [CNT_W-1:0] ZERO_C   = CNT_W'(0);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [7:0]       STARVE_C = 8'(STARVE_LIMIT);

   typedef enum logic [0:0] {
      ST_NORMAL = 1'b0,
      ST_DRAIN  = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      GNT_IDLE   = 2'b00,
      GNT_LOOKUP = 2'b01,
      GNT_UPDATE = 2'b10
   } grant_t;

   // The index hash has no carry, so adjacent PCs never alias through arithmetic.
   function automatic logic [3:0] bht_hash(input logic [3:0] pc, input logic [3:0] ghr);
      return pc ^ ghr;
   endfunction

   state_t           state_r;
   grant_t           grant_s;
   logic [3:0]       ghr_r;
   logic [7:0]       wait_cnt_r;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_nxt_s;
   logic [PTR_W-1:0] head_r;
   logic [PTR_W-1:0] tail_r;
   logic [3:0]       fifo_index_r   [DEPTH];
   logic             fifo_outcome_r [DEPTH];

   logic             nonempty_s;
   logic             starved_s;
   logic             enq_s;
   logic             deq_s;
   logic [3:0]       head_index_s;
   logic             head_outcome_s;

   assign head_index_s   = fifo_index_r[head_r];
   assign head_outcome_s = fifo_outcome_r[head_r];

   // Every status decision uses the registered count. An entry enqueued in this
   // cycle therefore becomes eligible for a grant only in the next cycle.
   assign nonempty_s = (count_r != ZERO_C);
   assign starved_s  = nonempty_s && (wait_cnt_r == STARVE_C);
   assign upd_ready  = (count_r < FULL_C);
   assign enq_s      = upd_valid && upd_ready;
   assign deq_s      = (grant_s == GNT_UPDATE);

   // Per-cycle arbitration: one grant of LOOKUP, UPDATE or IDLE.
   always_comb begin
      grant_s = GNT_IDLE;
      if (!reset_n) begin
         // Hold the BHT port quiet while reset is asserted, whatever the inputs are.
         grant_s = GNT_IDLE;
      end else if (state_r == ST_DRAIN) begin
         if (nonempty_s) begin
            grant_s = GNT_UPDATE;
         end else begin
            grant_s = GNT_IDLE;
         end
      end else if (starved_s) begin
         grant_s = GNT_UPDATE;
      end else if (lookup_valid) begin
         grant_s = GNT_LOOKUP;
      end else if (nonempty_s) begin
         grant_s = GNT_UPDATE;
      end else begin
         grant_s = GNT_IDLE;
      end
   end

   // Drive the BHT port from the grant for this cycle.
   always_comb begin
      bht_index     = 4'h0;
      bht_update_en = 1'b0;
      bht_outcome   = 1'b0;
      lookup_ready  = 1'b0;
      case (grant_s)
         GNT_LOOKUP: begin
            bht_index    = bht_hash(lookup_pc, ghr_r);
            lookup_ready = 1'b1;
         end
         GNT_UPDATE: begin
            bht_index     = head_index_s;
            bht_outcome   = head_outcome_s;
            bht_update_en = 1'b1;
         end
         default: begin
            bht_index     = 4'h0;
            bht_update_en = 1'b0;
            bht_outcome   = 1'b0;
            lookup_ready  = 1'b0;
         end
      endcase
   end

   // Occupancy after this cycle's enqueue and dequeue.
   always_comb begin
      count_nxt_s = count_r;
      case ({enq_s, deq_s})
         2'b10:   count_nxt_s = count_r + ONE_C;
         2'b01:   count_nxt_s = count_r - ONE_C;
         default: count_nxt_s = count_r;
      endcase
   end

   // Scheduler FSM, pointers, GHR, starvation counter and the prediction result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_NORMAL;
         ghr_r      <= 4'h0;
         wait_cnt_r <= 8'h00;
         count_r    <= ZERO_C;
         head_r     <= '0;
         tail_r     <= '0;
         pred_valid <= 1'b0;
         pred_taken <= 1'b0;
         pred_index <= 4'h0;
      end else begin
         count_r <= count_nxt_s;

         if (enq_s) begin
            tail_r <= tail_r + PTR_ONE;
         end
         if (deq_s) begin
            head_r <= head_r + PTR_ONE;
            ghr_r  <= {ghr_r[2:0], head_outcome_s};
         end

         // Count only the cycles in which queued work waits behind lookups.
         if (!nonempty_s || deq_s) begin
            wait_cnt_r <= 8'h00;
         end else if (wait_cnt_r < STARVE_C) begin
            wait_cnt_r <= wait_cnt_r + 8'h01;
         end

         // DRAIN uses hysteresis: it is entered at full and left at half full.
         case (state_r)
            ST_NORMAL: begin
               if (count_nxt_s == FULL_C) begin
                  state_r <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (count_nxt_s <= HALF_C) begin
                  state_r <= ST_NORMAL;
               end
            end
            default: state_r <= ST_NORMAL;
         endcase

         pred_valid <= (grant_s == GNT_LOOKUP);
         if (grant_s == GNT_LOOKUP) begin
            pred_taken <= bht_prediction;
            pred_index <= bht_index;
         end
      end
   end

   // Update FIFO storage. It is cleared on reset so that no stale entry can reach the BHT.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_index_r[i]   <= 4'h0;
            fifo_outcome_r[i] <= 1'b0;
         end
      end else if (enq_s) begin
         fifo_index_r[tail_r]   <= upd_index;
         fifo_outcome_r[tail_r] <= upd_outcome;
      end
   end

`ifdef BHT_SCHED_PERF_EN
   logic stall_s;
   logic forced_s;

   assign stall_s  = lookup_valid && !lookup_ready;
   assign forced_s = deq_s && ((state_r == ST_DRAIN) || starved_s);

   // Saturating performance counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lookup_stall_cnt <= 16'h0000;
         forced_upd_cnt   <= 16'h0000;
      end else begin
         if (stall_s && (lookup_stall_cnt != 16'hFFFF)) begin
            lookup_stall_cnt <= lookup_stall_cnt + 16'h0001;
         end
         if (forced_s && (forced_upd_cnt != 16'hFFFF)) begin
            forced_upd_cnt <= forced_upd_cnt + 16'h0001;
         end
      end
   end
`endif

endmodule
